llc_set_bufs: RTL and testbench
===============================

LLC_SET_BUFS -- requirements
Module: llc_set_bufs

Interface
REQ-001 Parameters: none; LLC_WAYS, LLC_WAY_BITS, LLC_SET_BITS are taken from the shared cache constants.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 load_valid  in  1  request to buffer a set; load_ready  out  1  block can accept; load_set  in  LLC_SET_BITS  set index.
REQ-005 rd_en  out  1  memory read strobe; rd_set  out  LLC_SET_BITS  read address.
REQ-006 rd_tags[LLC_WAYS]  in  llc_tag_t  read tags; rd_states[LLC_WAYS]  in  llc_state_t  read states; rd_evict_way  in  llc_way_t  stored replacement pointer; all valid exactly 1 cycle after rd_en.
REQ-007 tags_buf[LLC_WAYS]  out  llc_tag_t; states_buf[LLC_WAYS]  out  llc_state_t; evict_way_buf  out  llc_way_t; bufs_valid  out  1  buffer holds a loaded set (feeds way lookup).
REQ-008 upd_en  in  1; upd_way  in  llc_way_t; upd_tag  in  llc_tag_t; upd_state  in  llc_state_t  single-way buffer update.
REQ-009 evict_incr  in  1  advance replacement pointer by one.
REQ-010 release  in  1  finish with current set; wr_en  out  1; wr_set  out  LLC_SET_BITS; wr_tags, wr_states  out  per-way arrays; wr_evict_way  out  llc_way_t  write-back port.

Function
REQ-011 FSM states IDLE, READ, HOLD, WB; reset state IDLE.
REQ-012 load_ready SHALL be 1 only in IDLE.
REQ-013 IDLE with load_valid: rd_en=1 and rd_set=load_set (combinational), latch set into cur_set, go READ.
REQ-014 READ: capture rd_tags/rd_states/rd_evict_way into buffers, clear dirty flag, go HOLD; bufs_valid rises the cycle after capture (load-to-valid latency 2 cycles).
REQ-015 HOLD: bufs_valid=1; upd_en writes upd_tag/upd_state into way upd_way and sets dirty.
REQ-016 HOLD: evict_incr sets evict_way_buf to (evict_way_buf+1) mod LLC_WAYS (wraps LLC_WAYS-1 -> 0) and sets dirty.
REQ-017 upd_en and evict_incr in the same cycle SHALL both take effect.
REQ-018 HOLD with release: if dirty, or upd_en/evict_incr in the same cycle, go WB; else go IDLE with no write.
REQ-019 Updates coincident with release SHALL be included in the write-back data.
REQ-020 WB: wr_en=1 for exactly one cycle with wr_set=cur_set and buffer contents; bufs_valid=0; go IDLE.
REQ-021 upd_en, evict_incr, release outside HOLD SHALL be ignored.
REQ-022 load_valid outside IDLE SHALL be ignored (not accepted, load_ready=0).
REQ-023 rd_en and wr_en SHALL never be asserted in the same cycle.

Reset
REQ-024 On rst low: state IDLE, bufs_valid=0, rd_en=0, wr_en=0, dirty=0, cur_set=0, evict_way_buf=0, all tags_buf=0, all states_buf=INVALID.
REQ-025 Reset during READ or HOLD SHALL discard the set without write-back.

Structure
REQ-026 llc_tag_t, llc_state_t, llc_way_t, state encodings (INVALID, VALID, SD, ...) and LLC_* constants SHALL come from the shared cache types/constants package.
REQ-027 FSM state enum is local to the module.
REQ-028 No sub-module; outputs feed llc_lookup_way directly.

Verification
REQ-029 Load set 5 with rd_evict_way=2, then release with no updates -> bufs_valid at cycle +2, no wr_en, load_ready back to 1.
REQ-030 Load, upd_en way 3 tag 0x1A state VALID, release -> one wr_en cycle, wr_set=5, wr_tags[3]=0x1A, wr_states[3]=VALID.
REQ-031 evict_way_buf=LLC_WAYS-1, evict_incr -> evict_way_buf=0, release -> wr_evict_way=0.
REQ-032 upd_en, evict_incr and release in the same cycle on a clean set -> WB entered, write contains both updates.
REQ-033 load_valid held in HOLD -> ignored, no rd_en; rst low in HOLD after update -> no wr_en, all outputs at reset values.

Source files
------------

// File: rtl/llc_set_bufs_pkg.sv
// Shared LLC cache constants and types: geometry, tag/state/way types,
// line-state encodings, and the replacement-pointer advance helper.
package llc_set_bufs_pkg;

  localparam int unsigned LLC_WAYS       = 8;
  localparam int unsigned LLC_WAY_BITS   = 3;
  localparam int unsigned LLC_SET_BITS   = 4;
  localparam int unsigned LLC_TAG_BITS   = 8;
  localparam int unsigned LLC_STATE_BITS = 2;

  typedef logic [LLC_TAG_BITS-1:0]   llc_tag_t;
  typedef logic [LLC_STATE_BITS-1:0] llc_state_t;
  typedef logic [LLC_WAY_BITS-1:0]   llc_way_t;
  typedef logic [LLC_SET_BITS-1:0]   llc_set_t;

  localparam llc_state_t INVALID = 2'd0;
  localparam llc_state_t VALID   = 2'd1;
  localparam llc_state_t SD      = 2'd2;
  localparam llc_state_t DIRTY   = 2'd3;

  // Round-robin pointer step; explicit wrap keeps it correct for non-power-of-2 way counts.
  function automatic llc_way_t llc_way_inc(input llc_way_t w);
    return (w == llc_way_t'(LLC_WAYS - 1)) ? llc_way_t'(0) : w + llc_way_t'(1);
  endfunction

endpackage

// File: rtl/llc_set_bufs.sv
// Holds one LLC set (tags, states, replacement pointer) read from the arrays,
// applies single-way updates while held, and writes it back only if modified.
module llc_set_bufs
  import llc_set_bufs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  llc_set_t    load_set,
  output logic        rd_en,
  output llc_set_t    rd_set,
  input  llc_tag_t    rd_tags      [LLC_WAYS],
  input  llc_state_t  rd_states    [LLC_WAYS],
  input  llc_way_t    rd_evict_way,
  output llc_tag_t    tags_buf     [LLC_WAYS],
  output llc_state_t  states_buf   [LLC_WAYS],
  output llc_way_t    evict_way_buf,
  output logic        bufs_valid,
  input  logic        upd_en,
  input  llc_way_t    upd_way,
  input  llc_tag_t    upd_tag,
  input  llc_state_t  upd_state,
  input  logic        evict_incr,
  input  logic        release_set,
  output logic        wr_en,
  output llc_set_t    wr_set,
  output llc_tag_t    wr_tags      [LLC_WAYS],
  output llc_state_t  wr_states    [LLC_WAYS],
  output llc_way_t    wr_evict_way
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0] state_q, state_d;
  llc_set_t   cur_set_q, cur_set_d;
  logic       dirty_q, dirty_d;
  llc_tag_t   tags_q [LLC_WAYS];
  llc_tag_t   tags_d [LLC_WAYS];
  llc_state_t states_q [LLC_WAYS];
  llc_state_t states_d [LLC_WAYS];
  llc_way_t   evict_q, evict_d;
  logic       bufs_valid_q, bufs_valid_d;
  logic       load_ready_q, load_ready_d;
  logic       wr_en_q, wr_en_d;

  // Next-state, buffer update and the combinational array-read strobe.
  always_comb begin
    state_d   = state_q;
    cur_set_d = cur_set_q;
    dirty_d   = dirty_q;
    tags_d    = tags_q;
    states_d  = states_q;
    evict_d   = evict_q;
    rd_en     = 1'b0;
    rd_set    = load_set;

    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          rd_en     = 1'b1;
          cur_set_d = load_set;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        tags_d   = rd_tags;
        states_d = rd_states;
        evict_d  = rd_evict_way;
        dirty_d  = 1'b0;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (upd_en) begin
          tags_d[upd_way]   = upd_tag;
          states_d[upd_way] = upd_state;
          dirty_d           = 1'b1;
        end
        if (evict_incr) begin
          evict_d = llc_way_inc(evict_q);
          dirty_d = 1'b1;
        end
        // dirty_d already folds in same-cycle updates, so they reach the write-back.
        if (release_set) begin
          state_d = dirty_d ? S_WB : S_IDLE;
        end
      end
      S_WB: begin
        dirty_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    bufs_valid_d = (state_d == S_HOLD);
    load_ready_d = (state_d == S_IDLE);
    wr_en_d      = (state_d == S_WB);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cur_set_q    <= '0;
      dirty_q      <= 1'b0;
      evict_q      <= '0;
      bufs_valid_q <= 1'b0;
      load_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      for (int i = 0; i < int'(LLC_WAYS); i++) begin
        tags_q[i]   <= '0;
        states_q[i] <= INVALID;
      end
    end else begin
      state_q      <= state_d;
      cur_set_q    <= cur_set_d;
      dirty_q      <= dirty_d;
      evict_q      <= evict_d;
      bufs_valid_q <= bufs_valid_d;
      load_ready_q <= load_ready_d;
      wr_en_q      <= wr_en_d;
      tags_q       <= tags_d;
      states_q     <= states_d;
    end
  end

  assign load_ready    = load_ready_q;
  assign bufs_valid    = bufs_valid_q;
  assign tags_buf      = tags_q;
  assign states_buf    = states_q;
  assign evict_way_buf = evict_q;
  assign wr_en         = wr_en_q;
  assign wr_set        = cur_set_q;
  assign wr_tags       = tags_q;
  assign wr_states     = states_q;
  assign wr_evict_way  = evict_q;

endmodule

// File: tb/tb_llc_set_bufs.sv
// Bench for llc_set_bufs: directed vector table, random transactions against a
// set-level memory/buffer model, and hand sequences for reset and ignored inputs.
module tb_llc_set_bufs;
  import llc_set_bufs_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid, load_ready;
  llc_set_t   load_set;
  logic       rd_en;
  llc_set_t   rd_set;
  llc_tag_t   rd_tags [LLC_WAYS];
  llc_state_t rd_states [LLC_WAYS];
  llc_way_t   rd_evict_way;
  llc_tag_t   tags_buf [LLC_WAYS];
  llc_state_t states_buf [LLC_WAYS];
  llc_way_t   evict_way_buf;
  logic       bufs_valid;
  logic       upd_en;
  llc_way_t   upd_way;
  llc_tag_t   upd_tag;
  llc_state_t upd_state;
  logic       evict_incr, release_set;
  logic       wr_en;
  llc_set_t   wr_set;
  llc_tag_t   wr_tags [LLC_WAYS];
  llc_state_t wr_states [LLC_WAYS];
  llc_way_t   wr_evict_way;

  always #5 clk = ~clk;

  llc_set_bufs dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready), .load_set(load_set),
    .rd_en(rd_en), .rd_set(rd_set),
    .rd_tags(rd_tags), .rd_states(rd_states), .rd_evict_way(rd_evict_way),
    .tags_buf(tags_buf), .states_buf(states_buf), .evict_way_buf(evict_way_buf),
    .bufs_valid(bufs_valid),
    .upd_en(upd_en), .upd_way(upd_way), .upd_tag(upd_tag), .upd_state(upd_state),
    .evict_incr(evict_incr), .release_set(release_set),
    .wr_en(wr_en), .wr_set(wr_set), .wr_tags(wr_tags), .wr_states(wr_states),
    .wr_evict_way(wr_evict_way)
  );

  // Backing arrays: the bench's picture of what the cache memory holds per set.
  llc_tag_t   mem_tags   [16][LLC_WAYS];
  llc_state_t mem_states [16][LLC_WAYS];
  llc_way_t   mem_ev     [16];

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  // Read port answers one cycle after rd_en; garbage otherwise to expose mistimed capture.
  always @(posedge clk) begin
    for (int w = 0; w < int'(LLC_WAYS); w++) begin
      rd_tags[w]   <= rd_en ? mem_tags[rd_set][w]   : llc_tag_t'($urandom);
      rd_states[w] <= rd_en ? mem_states[rd_set][w] : llc_state_t'($urandom);
    end
    rd_evict_way <= rd_en ? mem_ev[rd_set] : llc_way_t'($urandom);
    if (wr_en) wr_cnt <= wr_cnt + 1;
  end

  typedef struct {
    bit         upd;
    llc_way_t   way;
    llc_tag_t   tag;
    llc_state_t st;
    bit         inc;
    bit         rel;
    bit         noise;
  } op_t;

  typedef struct {
    int set; int ev0;
    bit upd; int way; int tag; int st; bit inc; bit coinc;
    bit exp_wr; int exp_ev;
  } vec_t;

  op_t  ops[$];
  bit   res_wrote;
  int   res_ev;
  llc_tag_t   res_tags [LLC_WAYS];
  llc_state_t res_states [LLC_WAYS];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; upd_en = 1'b0; evict_incr = 1'b0; release_set = 1'b0;
  endtask

  task automatic chk_bufs(input string tag, input llc_tag_t et[LLC_WAYS],
                          input llc_state_t es[LLC_WAYS], input llc_way_t ev);
    for (int w = 0; w < int'(LLC_WAYS); w++) begin
      chk({tag, "_tag"}, int'(tags_buf[w]), int'(et[w]));
      chk({tag, "_state"}, int'(states_buf[w]), int'(es[w]));
    end
    chk({tag, "_evict"}, int'(evict_way_buf), int'(ev));
  endtask

  // Load a set, apply the queued hold-cycle ops (last one releases), check the write-back.
  task automatic run_txn(input llc_set_t set);
    llc_tag_t   et [LLC_WAYS];
    llc_state_t es [LLC_WAYS];
    llc_way_t   ev;
    bit         dirty;
    int         n, wc0;
    n = 0;
    while (!load_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("load_ready_wait", int'(load_ready), 1);
    wc0 = wr_cnt;
    load_valid = 1'b1; load_set = set; #1;
    chk("rd_en_on_load", int'(rd_en), 1);
    chk("rd_set", int'(rd_set), int'(set));
    @(posedge clk); #1;
    // Read cycle: everything driven here must be ignored.
    load_valid = 1'b1; load_set = llc_set_t'($urandom);
    upd_en = 1'b1; upd_way = llc_way_t'($urandom); upd_tag = llc_tag_t'($urandom);
    upd_state = llc_state_t'($urandom); evict_incr = 1'b1; release_set = 1'b1; #1;
    chk("rd_en_in_read", int'(rd_en), 0);
    chk("load_ready_in_read", int'(load_ready), 0);
    chk("bufs_valid_in_read", int'(bufs_valid), 0);
    @(posedge clk); #1;
    idle_inputs();
    for (int w = 0; w < int'(LLC_WAYS); w++) begin
      et[w] = mem_tags[set][w];
      es[w] = mem_states[set][w];
    end
    ev = mem_ev[set];
    dirty = 1'b0;
    chk("bufs_valid_latency2", int'(bufs_valid), 1);
    chk_bufs("capture", et, es, ev);
    res_ev = int'(evict_way_buf);
    foreach (ops[i]) begin
      upd_en = ops[i].upd; upd_way = ops[i].way; upd_tag = ops[i].tag; upd_state = ops[i].st;
      evict_incr = ops[i].inc; release_set = ops[i].rel;
      load_valid = ops[i].noise; load_set = llc_set_t'($urandom); #1;
      chk("rd_en_in_hold", int'(rd_en), 0);
      chk("load_ready_in_hold", int'(load_ready), 0);
      @(posedge clk); #1;
      idle_inputs();
      if (ops[i].upd) begin et[ops[i].way] = ops[i].tag; es[ops[i].way] = ops[i].st; end
      if (ops[i].inc) ev = llc_way_t'((int'(ev) + 1) % int'(LLC_WAYS));
      dirty = dirty | ops[i].upd | ops[i].inc;
      if (ops[i].rel) break;
      chk("bufs_valid_hold", int'(bufs_valid), 1);
      chk_bufs("hold", et, es, ev);
    end
    res_wrote = wr_en;
    chk("bufs_valid_after_release", int'(bufs_valid), 0);
    if (dirty) begin
      chk("wr_en_wb", int'(wr_en), 1);
      chk("wr_set", int'(wr_set), int'(set));
      for (int w = 0; w < int'(LLC_WAYS); w++) begin
        chk("wr_tags", int'(wr_tags[w]), int'(et[w]));
        chk("wr_states", int'(wr_states[w]), int'(es[w]));
        mem_tags[set][w] = et[w];
        mem_states[set][w] = es[w];
      end
      chk("wr_evict_way", int'(wr_evict_way), int'(ev));
      mem_ev[set] = ev;
      res_ev = int'(wr_evict_way);
      res_tags = wr_tags;
      res_states = wr_states;
      @(posedge clk); #1;
      chk("wr_en_one_cycle", int'(wr_en), 0);
    end else begin
      chk("wr_en_clean", int'(wr_en), 0);
    end
    chk("load_ready_back", int'(load_ready), 1);
    chk("write_count", wr_cnt - wc0, int'(dirty));
  endtask

  vec_t tbl [6];

  initial begin
    int wc0;
    idle_inputs();
    load_set = '0; upd_way = '0; upd_tag = '0; upd_state = INVALID;
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < int'(LLC_WAYS); w++) begin
        mem_tags[s][w] = llc_tag_t'($urandom);
        mem_states[s][w] = llc_state_t'($urandom);
      end
      mem_ev[s] = llc_way_t'($urandom);
    end

    // Reset values.
    #12;
    chk("rst_bufs_valid", int'(bufs_valid), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_load_ready", int'(load_ready), 1);
    chk("rst_evict", int'(evict_way_buf), 0);
    chk("rst_tag0", int'(tags_buf[0]), 0);
    chk("rst_state7", int'(states_buf[7]), int'(INVALID));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    //         set ev0 upd way tag    st          inc co  wr ev
    tbl[0] = '{5,  2,  0,  0,  0,     0,          0,  0,  0, 2};
    tbl[1] = '{5,  2,  1,  3,  'h1A,  int'(VALID), 0, 0,  1, 2};
    tbl[2] = '{9,  7,  0,  0,  0,     0,          1,  0,  1, 0};
    tbl[3] = '{3,  4,  1,  6,  'h55,  int'(SD),   1,  1,  1, 5};
    tbl[4] = '{12, 7,  1,  0,  'hFF,  int'(DIRTY), 1, 1,  1, 0};
    tbl[5] = '{0,  0,  0,  0,  0,     0,          0,  0,  0, 0};

    foreach (tbl[i]) begin
      op_t o;
      mem_ev[tbl[i].set] = llc_way_t'(tbl[i].ev0);
      ops.delete();
      o = '{upd: tbl[i].upd, way: llc_way_t'(tbl[i].way), tag: llc_tag_t'(tbl[i].tag),
            st: llc_state_t'(tbl[i].st), inc: tbl[i].inc, rel: tbl[i].coinc, noise: 1'b1};
      if (tbl[i].upd || tbl[i].inc) ops.push_back(o);
      if (!(tbl[i].coinc && (tbl[i].upd || tbl[i].inc)))
        ops.push_back('{upd: 1'b0, way: '0, tag: '0, st: INVALID, inc: 1'b0, rel: 1'b1, noise: 1'b1});
      run_txn(llc_set_t'(tbl[i].set));
      chk($sformatf("vec%0d_wrote", i), int'(res_wrote), int'(tbl[i].exp_wr));
      chk($sformatf("vec%0d_evict", i), res_ev, tbl[i].exp_ev);
      if (tbl[i].exp_wr && tbl[i].upd) begin
        chk($sformatf("vec%0d_tag", i), int'(res_tags[tbl[i].way]), tbl[i].tag);
        chk($sformatf("vec%0d_state", i), int'(res_states[tbl[i].way]), tbl[i].st);
      end
    end

    // Random transactions against the set-level model.
    for (int t = 0; t < 40; t++) begin
      int nops;
      nops = $urandom_range(0, 4);
      ops.delete();
      for (int k = 0; k <= nops; k++) begin
        op_t o;
        o.upd = ($urandom_range(0, 2) == 0);
        o.way = llc_way_t'($urandom);
        o.tag = llc_tag_t'($urandom);
        o.st  = llc_state_t'($urandom);
        o.inc = ($urandom_range(0, 3) == 0);
        o.rel = (k == nops);
        o.noise = $urandom_range(0, 1) == 1;
        ops.push_back(o);
      end
      run_txn(llc_set_t'($urandom_range(0, 15)));
    end

    // Reset while holding a modified set: discarded, no write-back.
    mem_ev[7] = 3'd3;
    load_valid = 1'b1; load_set = 4'd7;
    @(posedge clk); #1; load_valid = 1'b0;
    @(posedge clk); #1;
    upd_en = 1'b1; upd_way = 3'd1; upd_tag = 8'h77; upd_state = VALID; evict_incr = 1'b1;
    @(posedge clk); #1; idle_inputs();
    chk("pre_rst_tag1", int'(tags_buf[1]), 'h77);
    chk("pre_rst_evict", int'(evict_way_buf), 4);
    wc0 = wr_cnt;
    release_set = 1'b1;
    rst = 1'b0; #2;
    chk("hold_rst_bufs_valid", int'(bufs_valid), 0);
    chk("hold_rst_wr_en", int'(wr_en), 0);
    chk("hold_rst_load_ready", int'(load_ready), 1);
    chk("hold_rst_wr_set", int'(wr_set), 0);
    chk_bufs("hold_rst", '{default: llc_tag_t'(0)}, '{default: INVALID}, llc_way_t'(0));
    @(negedge clk); rst = 1'b1; release_set = 1'b0;
    // Ops in idle are ignored.
    upd_en = 1'b1; upd_way = 3'd2; upd_tag = 8'h33; evict_incr = 1'b1; release_set = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1; idle_inputs();
    chk("idle_ops_tag2", int'(tags_buf[2]), 0);
    chk("idle_ops_evict", int'(evict_way_buf), 0);
    chk("idle_ops_load_ready", int'(load_ready), 1);
    @(posedge clk); #1;
    chk("rst_no_write", wr_cnt - wc0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
